// File: rtl/brick_ctrl_pkg.sv
// Shared definitions for the falling-brick controller: field widths,
// state / request-kind encodings, the brick record and cell expansion.
package brick_ctrl_pkg;

  localparam int BOARD_W_DEF   = 10;
  localparam int BOARD_H_DEF   = 20;
  localparam int BRICK_LEN     = 3;
  localparam int DIR_LEN       = 2;
  localparam int COORD_LEN     = 5;
  localparam int POS_LEN       = 2 * COORD_LEN;
  localparam int BRICK_POS_LEN = 4 * POS_LEN;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_LOCK  = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  // What produced the candidate under CHECK; decides the no-fit outcome.
  typedef enum logic [1:0] {
    K_SPAWN = 2'd0,
    K_SHIFT = 2'd1,
    K_DOWN  = 2'd2,
    K_HARD  = 2'd3
  } kind_e;

  typedef struct packed {
    logic [BRICK_LEN-1:0] typ;
    logic [DIR_LEN-1:0]   dir;
    logic [POS_LEN-1:0]   pos;
  } brick_t;

  // Position word is {y, x}.
  function automatic logic [POS_LEN-1:0] make_pos(input logic [COORD_LEN-1:0] x,
                                                  input logic [COORD_LEN-1:0] y);
    return {y, x};
  endfunction

  // x^3 + x^2 + 1 Fibonacci LFSR; 001 -> 010 -> 101 -> 011 -> 111 -> 110 -> 100.
  function automatic logic [2:0] lfsr_next(input logic [2:0] s);
    return {s[1:0], s[2] ^ s[1]};
  endfunction

  // Expand a brick to its four absolute cells. Offsets are non-negative and
  // live in an s x s box; each rotation step maps (dx,dy) -> (s-1-dy, dx).
  // Coordinates wrap in COORD_LEN bits so stepping off the left/top edge
  // lands far out of range and fails the bounds test.
  function automatic logic [BRICK_POS_LEN-1:0] brick_cells(input brick_t b);
    logic [15:0] shp;        // cell3..cell0, each {dy,dx}
    logic [1:0]  s1;
    logic [1:0]  tx, ty;
    logic [BRICK_POS_LEN-1:0] cells;
    s1 = 2'd2;
    case (b.typ)
      3'd1: begin s1 = 2'd1; shp = {2'd1,2'd1, 2'd1,2'd0, 2'd0,2'd1, 2'd0,2'd0}; end // O
      3'd2: begin s1 = 2'd3; shp = {2'd1,2'd3, 2'd1,2'd2, 2'd1,2'd1, 2'd1,2'd0}; end // I
      3'd3: shp = {2'd1,2'd2, 2'd1,2'd1, 2'd1,2'd0, 2'd0,2'd1};                     // T
      3'd4: shp = {2'd1,2'd1, 2'd1,2'd0, 2'd0,2'd2, 2'd0,2'd1};                     // S
      3'd5: shp = {2'd1,2'd2, 2'd1,2'd1, 2'd0,2'd1, 2'd0,2'd0};                     // Z
      3'd6: shp = {2'd1,2'd2, 2'd1,2'd1, 2'd1,2'd0, 2'd0,2'd0};                     // J
      3'd7: shp = {2'd1,2'd2, 2'd1,2'd1, 2'd1,2'd0, 2'd0,2'd2};                     // L
      default: shp = '0;
    endcase
    for (int r = 0; r < 3; r++) begin
      if (r < int'(b.dir)) begin
        for (int i = 0; i < 4; i++) begin
          tx = shp[i*4 +: 2];
          ty = shp[i*4+2 +: 2];
          shp[i*4 +: 4] = {tx, 2'(s1 - ty)};
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      cells[i*POS_LEN +: POS_LEN] =
        make_pos(b.pos[COORD_LEN-1:0] + {3'b000, shp[i*4 +: 2]},
                 b.pos[POS_LEN-1:COORD_LEN] + {3'b000, shp[i*4+2 +: 2]});
    end
    return cells;
  endfunction

endpackage

// File: rtl/brick_ctrl_fits.sv
// Combinational fit test: every cell of the brick must be on the board and
// land on an empty board cell (BRICK_LEN-wide field equal to zero).
module brick_ctrl_fits
  import brick_ctrl_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic [BRICK_POS_LEN-1:0]             brick_pos,
  input  logic [BOARD_W*BOARD_H*BRICK_LEN-1:0] board,
  output logic                                 fit
);

  logic [3:0] cell_ok;

  for (genvar g = 0; g < 4; g++) begin : g_cell
    logic [COORD_LEN-1:0] cx, cy;
    logic                 in_rng;
    int                   idx;
    assign cx     = brick_pos[g*POS_LEN +: COORD_LEN];
    assign cy     = brick_pos[g*POS_LEN+COORD_LEN +: COORD_LEN];
    assign in_rng = (int'(cx) < BOARD_W) && (int'(cy) < BOARD_H);
    // Out-of-range cells index field 0; in_rng masks the result anyway.
    assign idx    = in_rng ? (int'(cy) * BOARD_W + int'(cx)) * BRICK_LEN : 0;
    assign cell_ok[g] = in_rng && (board[idx +: BRICK_LEN] == '0);
  end

  assign fit = &cell_ok;

endmodule

// File: rtl/brick_ctrl.sv
// Active-brick sequencer: spawns bricks from an LFSR, arbitrates
// rotate/move/drop/gravity requests one per WAIT cycle, verifies each
// candidate against the committed board and hands bricks that can no longer
// fall to the board writer over lock_valid/lock_ack.
// Build option HARD_DROP_EN adds a hard_drop pulse input that drops the
// brick one row per CHECK cycle until it locks.
module brick_ctrl
  import brick_ctrl_pkg::*;
#(
  parameter int BOARD_W    = BOARD_W_DEF,
  parameter int BOARD_H    = BOARD_H_DEF,
  parameter int SPAWN_X    = 4,
  parameter int SPAWN_Y    = 0,
  parameter int GRAV_TICKS = 4
) (
  input  logic                                 clk_div22,
  input  logic                                 rst_1plus,
  input  logic                                 game_en,
  input  logic                                 move_l,
  input  logic                                 move_r,
  input  logic                                 rotate,
`ifdef HARD_DROP_EN
  input  logic                                 hard_drop,
`endif
  input  logic                                 soft_drop,
  input  logic [BOARD_W*BOARD_H*BRICK_LEN-1:0] board,
  input  logic                                 lock_ack,
  output logic [BRICK_LEN-1:0]                 brick_type,
  output logic [DIR_LEN-1:0]                   dir,
  output logic [POS_LEN-1:0]                   cur_pos,
  output logic                                 lock_valid,
  output logic [BRICK_POS_LEN-1:0]             lock_brick_pos,
  output logic                                 game_over
);

  localparam int GC_W = (GRAV_TICKS > 1) ? $clog2(GRAV_TICKS) : 1;
  localparam logic [POS_LEN-1:0] SPAWN_POS =
    {COORD_LEN'(SPAWN_Y), COORD_LEN'(SPAWN_X)};

  state_e                   state_q, state_d;
  kind_e                    kind_q, kind_d;
  brick_t                   cur_q, cur_d;
  brick_t                   cand_q, cand_d;
  logic [2:0]               lfsr_q, lfsr_d;
  logic [GC_W-1:0]          gcnt_q, gcnt_d;
  logic                     gpend_q, gpend_d;
  logic                     lock_valid_q, lock_valid_d;
  logic [BRICK_POS_LEN-1:0] lock_pos_q, lock_pos_d;
  logic                     game_over_q, game_over_d;

  logic [BRICK_POS_LEN-1:0] cand_cells, cur_cells;
  logic                     cand_fit;
  logic                     serve_down;
  logic [GC_W-1:0]          gbase;
  logic                     hard_req;

`ifdef HARD_DROP_EN
  assign hard_req = hard_drop;
`else
  assign hard_req = 1'b0;
`endif

  assign cand_cells = brick_cells(cand_q);
  assign cur_cells  = brick_cells(cur_q);

  brick_ctrl_fits #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_fits (
    .brick_pos (cand_cells),
    .board     (board),
    .fit       (cand_fit)
  );

  // Next-state: FSM transitions, request arbitration and the gravity timer.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    cur_d        = cur_q;
    cand_d       = cand_q;
    lfsr_d       = lfsr_q;
    gcnt_d       = gcnt_q;
    gpend_d      = gpend_q;
    lock_valid_d = lock_valid_q;
    lock_pos_d   = lock_pos_q;
    game_over_d  = game_over_q;
    serve_down   = 1'b0;
    gbase        = gcnt_q;

    case (state_q)
      ST_IDLE: if (game_en) state_d = ST_SPAWN;

      ST_SPAWN: begin
        cand_d  = '{typ: lfsr_q, dir: '0, pos: SPAWN_POS};
        kind_d  = K_SPAWN;
        lfsr_d  = lfsr_next(lfsr_q);
        gcnt_d  = '0;
        gpend_d = 1'b0;
        state_d = ST_CHECK;
      end

      ST_WAIT: begin
        if (!game_en) begin
          cur_d.typ = '0;
          state_d   = ST_IDLE;
        end else begin
          cand_d = cur_q;
          kind_d = K_SHIFT;
          if (rotate) begin
            cand_d.dir = cur_q.dir + 2'd1;
            state_d    = ST_CHECK;
          end else if (move_l) begin
            cand_d.pos[COORD_LEN-1:0] = cur_q.pos[COORD_LEN-1:0] - 5'd1;
            state_d = ST_CHECK;
          end else if (move_r) begin
            cand_d.pos[COORD_LEN-1:0] = cur_q.pos[COORD_LEN-1:0] + 5'd1;
            state_d = ST_CHECK;
          end else if (hard_req || soft_drop || gpend_q) begin
            cand_d.pos[POS_LEN-1:COORD_LEN] = cur_q.pos[POS_LEN-1:COORD_LEN] + 5'd1;
            kind_d     = hard_req ? K_HARD : K_DOWN;
            serve_down = 1'b1;
            state_d    = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (cand_fit) begin
          cur_d = cand_q;
          if (kind_q == K_HARD) begin
            // Keep descending without returning to WAIT.
            cand_d.pos[POS_LEN-1:COORD_LEN] = cand_q.pos[POS_LEN-1:COORD_LEN] + 5'd1;
          end else if (!game_en) begin
            cur_d.typ = '0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          case (kind_q)
            K_SPAWN: begin
              game_over_d = 1'b1;
              cur_d.typ   = '0;
              state_d     = ST_OVER;
            end
            K_DOWN, K_HARD: begin
              lock_valid_d = 1'b1;
              lock_pos_d   = cur_cells;
              state_d      = ST_LOCK;
            end
            default: begin
              if (!game_en) begin
                cur_d.typ = '0;
                state_d   = ST_IDLE;
              end else begin
                state_d = ST_WAIT;
              end
            end
          endcase
        end
      end

      ST_LOCK: begin
        if (lock_valid_q && lock_ack) begin
          lock_valid_d = 1'b0;
          cur_d.typ    = '0;
          state_d      = ST_SPAWN;
        end
      end

      ST_OVER: state_d = ST_OVER;

      default: state_d = ST_IDLE;
    endcase

    // Gravity ticks only while a brick is live; a served down request
    // restarts the period from this cycle and consumes the pending step.
    if (state_q == ST_WAIT || state_q == ST_CHECK) begin
      if (serve_down) begin
        gpend_d = 1'b0;
        gbase   = '0;
      end
      if (gbase == GC_W'(GRAV_TICKS - 1)) begin
        gcnt_d  = '0;
        gpend_d = 1'b1;
      end else begin
        gcnt_d = gbase + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_div22 or posedge rst_1plus) begin
    if (rst_1plus) begin
      state_q      <= ST_IDLE;
      kind_q       <= K_SPAWN;
      cur_q        <= '{typ: '0, dir: '0, pos: SPAWN_POS};
      cand_q       <= '{typ: '0, dir: '0, pos: SPAWN_POS};
      lfsr_q       <= 3'b001;
      gcnt_q       <= '0;
      gpend_q      <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_pos_q   <= '0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      cur_q        <= cur_d;
      cand_q       <= cand_d;
      lfsr_q       <= lfsr_d;
      gcnt_q       <= gcnt_d;
      gpend_q      <= gpend_d;
      lock_valid_q <= lock_valid_d;
      lock_pos_q   <= lock_pos_d;
      game_over_q  <= game_over_d;
    end
  end

  assign brick_type     = cur_q.typ;
  assign dir            = cur_q.dir;
  assign cur_pos        = cur_q.pos;
  assign lock_valid     = lock_valid_q;
  assign lock_brick_pos = lock_pos_q;
  assign game_over      = game_over_q;

endmodule

// File: doc/brick_ctrl.md
Name: brick_ctrl

Overview:
- Sequences the active falling brick: owns brick type, direction and position, and arbitrates move/rotate/gravity requests.
- Each candidate move is checked against the committed board through a `brick` instance. A brick that can no longer fall is handed to the board writer with a valid/ack handshake.
- Sits between the debounced one-pulse button logic and the board/display path, in the PLAYING state.

Parameters:
- BOARD_W, 10, board columns; x valid range 0..BOARD_W-1.
- BOARD_H, 20, board rows; y valid range 0..BOARD_H-1; y grows downward.
- SPAWN_X, 4, spawn column.
- SPAWN_Y, 0, spawn row.
- GRAV_TICKS, 4, clk_div22 cycles per gravity step (min 1).

Ports:
- clk_div22  in  1  block clock.
- rst_1plus  in  1  reset, asynchronous, active-high.
- game_en  in  1  level; high = play.
- move_l / move_r / rotate / soft_drop  in  1 each  one-cycle request pulses.
- board  in  `BOARD_SIZE  committed board; a cell is occupied when its `BRICK_LEN field is non-zero.
- lock_ack  in  1  board writer has merged the locked brick.
- brick_type  out  `BRICK_LEN  active type; 0 = none.
- dir  out  `DIR_LEN  active rotation, 0..3.
- cur_pos  out  `POS_LEN  active anchor position.
- lock_valid  out  1  locked brick available to the board writer.
- lock_brick_pos  out  `BRICK_POS_LEN  4 cells of the locked brick.
- game_over  out  1  sticky spawn-collision flag.

Behaviour:
- Reset (async) values:
  - brick_type=0, dir=0, cur_pos=MAKE_POS(SPAWN_X,SPAWN_Y), lock_valid=0, lock_brick_pos=0, game_over=0.
  - Internal: LFSR=3'b001, gravity counter=0, grav_pend=0, state IDLE.
- Type generator: 3-bit LFSR, x^3+x^2+1. It advances once per SPAWN, so it cycles through all values 1..7 and never produces 0.
- FSM states: IDLE, SPAWN, WAIT, CHECK, LOCK, OVER.
  - IDLE: go to SPAWN when game_en=1.
  - SPAWN: candidate = (LFSR value, dir 0, spawn pos). Clear grav_pend and the gravity counter. Go to CHECK with kind=SPAWN.
  - WAIT: serve at most one request per cycle, in fixed priority rotate > move_l > move_r > soft_drop > grav_pend.
    - Candidate: rotate = dir+1 mod 4; move_l = x-1; move_r = x+1; down = y+1.
    - Latch the candidate, then go to CHECK.
    - Lower-priority pulses in the same cycle are dropped. Pulses arriving outside WAIT are dropped.
  - CHECK: the candidate fits if all 4 cells have x<BOARD_W and y<BOARD_H (unsigned, so underflow wraps and fails) and every cell is unoccupied.
    - Fit: commit candidate to the outputs; go to WAIT. Outputs change 2 cycles after the request pulse.
    - No fit, kind move/rotate: discard candidate, outputs unchanged, go to WAIT.
    - No fit, kind down: go to LOCK.
    - No fit, kind SPAWN: game_over=1, brick_type=0, go to OVER.
    - A served down request (soft_drop or gravity) clears grav_pend and restarts the gravity counter.
  - LOCK: lock_valid=1 and lock_brick_pos = current cells, both held stable until lock_ack=1. On the lock_ack cycle: lock_valid=0, brick_type=0, go to SPAWN.
    - lock_ack while lock_valid=0 is ignored.
  - OVER: remains until reset; game_over stays 1.
- Gravity counter: runs only in WAIT/CHECK. When it reaches GRAV_TICKS-1 it sets grav_pend and wraps to 0. If grav_pend is already set it stays set; there is no backlog.
- game_en dropping to 0: from WAIT/CHECK go to IDLE after the current CHECK completes, with brick_type=0. LOCK always completes its handshake first.
- Reset mid-LOCK: lock_valid drops immediately. The board writer must treat reset as aborting the lock.

Optional Feature:
- HARD_DROP_EN.
- Defined: adds input hard_drop (1-bit pulse), priority just above soft_drop. Issues a down candidate every CHECK cycle (WAIT is skipped) until no fit, then goes to LOCK. Other requests are dropped meanwhile.
- Undefined: no hard_drop port; behaviour as above.

Decomposition:
- Shared header.v: BOARD_W/BOARD_H defaults, brick_ctrl state encodings (3-bit), request-kind encodings, BRICK_*, POS/DIR lengths, MAKE_POS/BRICK_GET_POS/POS2EXP macros.
- Sub-module brick_fits (combinational): inputs brick_pos and board; output fit.
- brick_ctrl instantiates one `brick` for the candidate and one for the current cells, and one brick_fits.

Test Plan:
- Reset, then game_en=1 → SPAWN then CHECK; brick_type=1 (LFSR 001), dir=0, cur_pos=(4,0) within 3 cycles; game_over=0.
- Empty board, move_l ×5 spaced 3 cycles → x goes 3,2,1,0; a further move_l at the left edge leaves cur_pos unchanged.
- rotate and move_r in the same cycle → only dir increments (0→1); x unchanged.
- GRAV_TICKS=4, no input → y increments every 4 cycles. At the floor the block enters LOCK, lock_valid=1 and is held 5 cycles with lock_ack=0; lock_ack=1 → lock_valid=0 next cycle, new brick_type=2.
- Board with spawn cells pre-filled → after spawn CHECK, game_over=1 and brick_type=0; game_over stays high through further requests until rst_1plus.
- HARD_DROP_EN: hard_drop at y=0 on empty 20-row board → lock_valid rises with the brick at the floor after one CHECK per row descended plus the final failing CHECK.
